keypad_scanner: RTL and testbench

Scans a 4×4 matrix keypad by strobing columns and reading debounced rows. Produces one qualified key event per physical press. Maintains a 4-digit BCD entry register whose outputs drive the seven-segment display driver's four digit inputs directly. It is the input-side counterpart of the display multiplexer: columns are time-multiplexed outward and row returns are sampled inward.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/digit_entry.sv | 44 ++++
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and lookup helpers for the keypad scanner and entry logic.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_CLR  = KEY_STAR;
  localparam logic [3:0] KEY_ENT  = KEY_HASH;

  // Translates a (row, column) matrix position into the printed key code.
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] rr;
    logic [3:0] cc;
    logic [3:0] code;
    rr = {2'b00, r};
    cc = {2'b00, c};
    if (c == 2'd3) begin
      code = 4'hA + rr;
    end else if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = rr * 4'd3 + cc + 4'd1;
    end
    return code;
  endfunction

  // Picks the lowest-numbered active-low row so simultaneous presses resolve deterministically.
  function automatic logic [1:0] lowestLow(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/digit_entry.sv
// Four-digit BCD entry register: numeric keys shift in from the right, '*' clears.
module digit_entry
  import keypad_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3
);

  logic [3:0] d0_q, d1_q, d2_q, d3_q;

  // Shift a new decimal digit in, clear on '*', ignore letters and '#'.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d0_q <= 4'd0;
      d1_q <= 4'd0;
      d2_q <= 4'd0;
      d3_q <= 4'd0;
    end else if (key_valid) begin
      if (key_code <= 4'd9) begin
        d3_q <= d2_q;
        d2_q <= d1_q;
        d1_q <= d0_q;
        d0_q <= key_code;
      end else if (key_code == KEY_CLR) begin
        d0_q <= 4'd0;
        d1_q <= 4'd0;
        d2_q <= 4'd0;
        d3_q <= 4'd0;
      end
    end
  end

  assign d0 = d0_q;
  assign d1 = d1_q;
  assign d2 = d2_q;
  assign d3 = d3_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, row sync, debounce FSM and one event per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 40
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       enter,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  scan_state_e   state_q, stateD;
  logic [CW-1:0] cnt_q, cntD;
  logic [1:0]    colIdx_q, colIdxD;
  logic [1:0]    capRow_q, capRowD;
  logic [DW-1:0] divCnt_q;
  logic [3:0]    rowMeta_q, rowSync_q;
  logic [3:0]    keyCode_q;
  logic          keyValid_q, enter_q;
  logic          tick;
  logic          capLow;
  logic [CW-1:0] cntInc;
  logic          eventD;
  logic [3:0]    codeD;

  assign tick   = (divCnt_q == DIV_LAST);
  assign capLow = ~rowSync_q[capRow_q];
  assign cntInc = cnt_q + CW'(1);

  // Two-flop synchronizer; resets to idle (all rows high) so reset never looks like a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= row;
      rowSync_q <= rowMeta_q;
    end
  end

  // Slot divider producing one tick per column slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) divCnt_q <= '0;
    else if (tick) divCnt_q <= '0;
    else           divCnt_q <= divCnt_q + DW'(1);
  end

  // Scanner state register with captured column, row and debounce count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      colIdx_q <= 2'd0;
      capRow_q <= 2'd0;
    end else begin
      state_q  <= stateD;
      cnt_q    <= cntD;
      colIdx_q <= colIdxD;
      capRow_q <= capRowD;
    end
  end

  // Next-state logic; everything only moves on a slot tick.
  always_comb begin
    stateD  = state_q;
    cntD    = cnt_q;
    colIdxD = colIdx_q;
    capRowD = capRow_q;
    eventD  = 1'b0;
    codeD   = keymap(capRow_q, colIdx_q);
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (rowSync_q != 4'hF) begin
            capRowD = lowestLow(rowSync_q);
            cntD    = CW'(1);
            codeD   = keymap(capRowD, colIdx_q);
            if (cntD == CNT_DONE) begin
              stateD = HELD;
              eventD = 1'b1;
            end else begin
              stateD = DEBOUNCE;
            end
          end else begin
            colIdxD = colIdx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (capLow) begin
            cntD = cntInc;
            if (cntInc == CNT_DONE) begin
              stateD = HELD;
              eventD = 1'b1;
            end
          end else begin
            stateD  = SCAN;
            cntD    = '0;
            colIdxD = colIdx_q + 2'd1;
          end
        end
        HELD: begin
          if (!capLow) begin
            cntD = CW'(1);
            if (cntD == CNT_DONE) begin
              stateD  = SCAN;
              cntD    = '0;
              colIdxD = colIdx_q + 2'd1;
            end else begin
              stateD = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!capLow) begin
            cntD = cntInc;
            if (cntInc == CNT_DONE) begin
              stateD  = SCAN;
              cntD    = '0;
              colIdxD = colIdx_q + 2'd1;
            end
          end else begin
            stateD = HELD;
            cntD   = '0;
          end
        end
        default: begin
          stateD = SCAN;
          cntD   = '0;
        end
      endcase
    end
  end

  // Registered event outputs so code, pulse and enter line up one clock after the accepting tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      enter_q    <= 1'b0;
    end else begin
      keyValid_q <= eventD;
      enter_q    <= eventD && (codeD == KEY_ENT);
      if (eventD) keyCode_q <= codeD;
    end
  end

  digit_entry u_digit_entry (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_valid (eventD),
    .key_code  (codeD),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3)
  );

  assign col       = ~(4'b0001 << colIdx_q);
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign enter     = enter_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from the strobed columns,
// expected events are queued at press time and a monitor checks every key_valid pulse.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       enter;
  logic [3:0] d0, d1, d2, d3;

  logic [15:0] keysDown = 16'h0000;
  int checks = 0;
  int failures = 0;
  int validCount = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic        ent;
    logic [15:0] digits;
  } exp_t;

  exp_t expQ[$];

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .enter     (enter),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3)
  );

  // Keypad model: a row is pulled low when a pressed key in it sits on the active column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keysDown[r*4 +: 4] & ~col)) row[r] = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && key_valid) begin
      validCount++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedValid got key_valid=1 code=%0h expected no event", key_code);
      end else begin
        e = expQ.pop_front();
        checkOutput("eventCode", 32'(key_code), 32'(e.code));
        checkOutput("eventEnter", 32'(enter), 32'(e.ent));
        checkOutput("eventDigits", 32'({d3, d2, d1, d0}), 32'(e.digits));
        checkOutput("eventHeld", 32'(key_held), 32'd1);
      end
    end
    if (reset_n && enter && !key_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL enterWithoutValid got enter=1 expected enter only with key_valid");
    end
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic applyStimulus(input int r, input int c, input bit down);
    keysDown[r*4 + c] = down;
  endtask

  task automatic expectEvent(input logic [3:0] code, input logic ent, input logic [15:0] digits);
    exp_t e;
    e.code   = code;
    e.ent    = ent;
    e.digits = digits;
    expQ.push_back(e);
  endtask

  task automatic waitForValid(input int startCount, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (validCount > startCount) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic waitHeldLow(input string name);
    for (int i = 0; i < 300 && key_held; i++) @(negedge clock);
    checkOutput(name, 32'(key_held), 32'd0);
  endtask

  task automatic pressKey(input int r, input int c, input logic [3:0] code,
                          input logic ent, input logic [15:0] digits);
    int start;
    start = validCount;
    expectEvent(code, ent, digits);
    applyStimulus(r, c, 1'b1);
    waitForValid(start, "validSeen");
    waitClocks(16);
    applyStimulus(r, c, 1'b0);
    waitHeldLow("heldFall");
    checkOutput("oneEventPerPress", 32'(validCount), 32'(start + 1));
    waitClocks(8);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] colSeq [4];
    int start;
    bit gone;
    colSeq[0] = 4'b1110;
    colSeq[1] = 4'b1101;
    colSeq[2] = 4'b1011;
    colSeq[3] = 4'b0111;

    // Reset values and idle column rotation.
    waitClocks(3);
    @(negedge clock);
    checkOutput("resetCol", 32'(col), 32'(4'b1110));
    checkOutput("resetCode", 32'(key_code), 32'd0);
    checkOutput("resetValid", 32'(key_valid), 32'd0);
    checkOutput("resetHeld", 32'(key_held), 32'd0);
    checkOutput("resetEnter", 32'(enter), 32'd0);
    checkOutput("resetDigits", 32'({d3, d2, d1, d0}), 32'd0);
    reset_n = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      repeat (SCAN_DIV) @(posedge clock);
      @(negedge clock);
      checkOutput("idleCol", 32'(col), 32'(colSeq[s % 4]));
    end
    checkOutput("idleNoValid", 32'(validCount), 32'd0);

    // Key 5 held for a long time: column frozen, held until release debounce completes.
    start = validCount;
    expectEvent(4'h5, 1'b0, 16'h0005);
    applyStimulus(1, 1, 1'b1);
    waitForValid(start, "key5Valid");
    for (int i = 0; i < 4; i++) begin
      waitClocks(16);
      @(negedge clock);
      checkOutput("frozenCol", 32'(col), 32'(4'b1101));
      checkOutput("heldHigh", 32'(key_held), 32'd1);
    end
    applyStimulus(1, 1, 1'b0);
    waitClocks(4);
    @(negedge clock);
    checkOutput("heldAfterRelease", 32'(key_held), 32'd1);
    waitHeldLow("key5HeldFall");
    checkOutput("key5Single", 32'(validCount), 32'(start + 1));
    waitClocks(8);

    // Press bounce on key 9: low for two ticks only, then back to scanning.
    start = validCount;
    gone = 1'b0;
    for (int i = 0; i < 40 && !gone; i++) begin
      @(negedge clock);
      if (col != 4'b1011) gone = 1'b1;
    end
    applyStimulus(2, 2, 1'b1);
    for (int i = 0; i < 40 && col != 4'b1011; i++) @(negedge clock);
    checkOutput("bounceColReached", 32'(col), 32'(4'b1011));
    waitClocks(8);
    #1;
    applyStimulus(2, 2, 1'b0);
    waitClocks(4);
    @(negedge clock);
    checkOutput("bounceBackToScan", 32'(col), 32'(4'b0111));
    waitClocks(16);
    checkOutput("bounceNoValid", 32'(validCount), 32'(start));

    // Release bounce on key 6: a re-press during release must not create a second event.
    start = validCount;
    expectEvent(4'h6, 1'b0, 16'h0056);
    applyStimulus(1, 2, 1'b1);
    waitForValid(start, "key6Valid");
    waitClocks(12);
    applyStimulus(1, 2, 1'b0);
    waitClocks(6);
    applyStimulus(1, 2, 1'b1);
    waitClocks(8);
    @(negedge clock);
    checkOutput("heldThroughBounce", 32'(key_held), 32'd1);
    applyStimulus(1, 2, 1'b0);
    waitHeldLow("key6HeldFall");
    checkOutput("noSecondEvent", 32'(validCount), 32'(start + 1));
    waitClocks(8);

    // Digit entry sequence, clear and enter.
    pressKey(0, 0, 4'h1, 1'b0, 16'h0561);
    pressKey(0, 1, 4'h2, 1'b0, 16'h5612);
    pressKey(0, 2, 4'h3, 1'b0, 16'h6123);
    pressKey(1, 0, 4'h4, 1'b0, 16'h1234);
    pressKey(1, 1, 4'h5, 1'b0, 16'h2345);
    pressKey(3, 0, 4'hE, 1'b0, 16'h0000);
    pressKey(3, 2, 4'hF, 1'b1, 16'h0000);
    @(negedge clock);
    checkOutput("digitsAfterHash", 32'({d3, d2, d1, d0}), 32'd0);

    // Keys 4 and 7 together resolve to 4; A pressed meanwhile is ignored.
    start = validCount;
    expectEvent(4'h4, 1'b0, 16'h0004);
    applyStimulus(1, 0, 1'b1);
    applyStimulus(2, 0, 1'b1);
    waitForValid(start, "key4Valid");
    applyStimulus(0, 3, 1'b1);
    waitClocks(40);
    checkOutput("noEventForA", 32'(validCount), 32'(start + 1));
    applyStimulus(1, 0, 1'b0);
    applyStimulus(2, 0, 1'b0);
    applyStimulus(0, 3, 1'b0);
    waitHeldLow("multiHeldFall");
    waitClocks(8);

    // Reset mid-HELD with key 8, then a fresh full debounce after reset.
    start = validCount;
    expectEvent(4'h8, 1'b0, 16'h0048);
    applyStimulus(2, 1, 1'b1);
    waitForValid(start, "key8Valid");
    waitClocks(10);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midResetCol", 32'(col), 32'(4'b1110));
    checkOutput("midResetHeld", 32'(key_held), 32'd0);
    checkOutput("midResetCode", 32'(key_code), 32'd0);
    checkOutput("midResetDigits", 32'({d3, d2, d1, d0}), 32'd0);
    waitClocks(3);
    @(negedge clock);
    start = validCount;
    expectEvent(4'h8, 1'b0, 16'h0008);
    reset_n = 1'b1;
    waitClocks(10);
    checkOutput("noEarlyEvent", 32'(validCount), 32'(start));
    waitForValid(start, "key8AfterReset");
    applyStimulus(2, 1, 1'b0);
    waitHeldLow("key8HeldFall");
    waitClocks(8);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
